// File: rtl/riscv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : riscv_pkg                                                 |
// | Brief    : Shared pipeline types for the RISC-V core hazard logic.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package riscv_pkg;

  localparam int REGW = 5;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_M    = 2'd1,
    FWD_W    = 2'd2
  } fwd_sel_t;

  typedef enum logic [0:0] {
    HZ_IDLE = 1'b0,
    HZ_WAIT = 1'b1
  } hz_state_t;

  // x0 is hard-wired to zero, so a write to it never produces a forwardable value.
  function automatic logic producer_hit(
    input logic            we,
    input logic [REGW-1:0] rd,
    input logic [REGW-1:0] rs
  );
    return we && (rd != '0) && (rd == rs);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_select.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fwd_select                                                |
// | Brief    : Per-operand forwarding select, M stage wins over W stage. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module fwd_select
  import riscv_pkg::*;
(
  input  logic [REGW-1:0] i_rs_e,
  input  logic [REGW-1:0] i_rd_m,
  input  logic            i_reg_write_m,
  input  logic [REGW-1:0] i_rd_w,
  input  logic            i_reg_write_w,
  output logic [1:0]      o_sel
);

  fwd_sel_t w_sel;

  always_comb begin
    w_sel = FWD_NONE;
    if (producer_hit(i_reg_write_m, i_rd_m, i_rs_e)) begin
      w_sel = FWD_M;
    end else if (producer_hit(i_reg_write_w, i_rd_w, i_rs_e)) begin
      w_sel = FWD_W;
    end
  end

  assign o_sel = w_sel;

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hazard_unit                                               |
// | Brief    : Forwarding selects, load-use stall FSM, branch flushes    |
// |            and a saturating stall-cycle counter.                     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module hazard_unit
  import riscv_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int CNTW     = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [REGW-1:0] rs1_d,
  input  logic [REGW-1:0] rs2_d,
  input  logic            use_rs1_d,
  input  logic            use_rs2_d,
  input  logic [REGW-1:0] rs1_e,
  input  logic [REGW-1:0] rs2_e,
  input  logic [REGW-1:0] rd_e,
  input  logic            mem_read_e,
  input  logic            branch_taken_e,
  input  logic [REGW-1:0] rd_m,
  input  logic            reg_write_m,
  input  logic [REGW-1:0] rd_w,
  input  logic            reg_write_w,
  output logic [1:0]      forward_a_o,
  output logic [1:0]      forward_b_o,
  output logic            stall_f_o,
  output logic            stall_d_o,
  output logic            flush_d_o,
  output logic            flush_e_o,
  output logic [CNTW-1:0] stall_cycles_o
);

  localparam int                c_cnt_w    = $clog2(LOAD_LAT + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(LOAD_LAT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic              c_multi    = (LOAD_LAT > 1);

  hz_state_t           r_state;
  hz_state_t           w_state;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [CNTW-1:0]     r_stall_cycles;
  logic                w_hz;

  fwd_select u_fwd_a (
    .i_rs_e        (rs1_e),
    .i_rd_m        (rd_m),
    .i_reg_write_m (reg_write_m),
    .i_rd_w        (rd_w),
    .i_reg_write_w (reg_write_w),
    .o_sel         (forward_a_o)
  );

  fwd_select u_fwd_b (
    .i_rs_e        (rs2_e),
    .i_rd_m        (rd_m),
    .i_reg_write_m (reg_write_m),
    .i_rd_w        (rd_w),
    .i_reg_write_w (reg_write_w),
    .o_sel         (forward_b_o)
  );

  assign w_hz = mem_read_e && (rd_e != '0) &&
                ((use_rs1_d && (rs1_d == rd_e)) || (use_rs2_d && (rs2_d == rd_e)));

  // Outputs decode from the state the register is about to take under reset,
  // so a reset issued mid-WAIT releases the pipeline in that same cycle.
  always_comb begin
    w_state   = rst_i ? HZ_IDLE : r_state;
    stall_f_o = 1'b0;
    stall_d_o = 1'b0;
    flush_d_o = 1'b0;
    flush_e_o = 1'b0;
    if (w_state == HZ_WAIT) begin
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
      flush_e_o = 1'b1;
      flush_d_o = branch_taken_e;
    end else if (branch_taken_e) begin
      flush_d_o = 1'b1;
      flush_e_o = 1'b1;
    end else if (w_hz) begin
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
      flush_e_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state        <= HZ_IDLE;
      r_cnt          <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (stall_f_o && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
      case (r_state)
        HZ_IDLE: begin
          if (c_multi && w_hz && !branch_taken_e) begin
            r_state <= HZ_WAIT;
            r_cnt   <= c_cnt_init;
          end
        end
        HZ_WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == c_cnt_one) begin
            r_state <= HZ_IDLE;
          end
        end
        default: begin
          r_state <= HZ_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign stall_cycles_o = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_hazard_unit                                            |
// | Brief    : Self-checking bench, three hazard_unit configurations.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_hazard_unit;
  import riscv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       use_rs1_d, use_rs2_d, mem_read_e, branch_taken_e, reg_write_m, reg_write_w;

  logic [1:0]  fa1, fb1, fa2, fb2, fa3, fb3;
  logic        sf1, sd1, fd1, fe1, sf2, sd2, fd2, fe2, sf3, sd3, fd3, fe3;
  logic [3:0]  sc1;
  logic [15:0] sc2, sc3;

  int checks   = 0;
  int failures = 0;
  bit checking = 1'b0;

  hazard_unit #(.LOAD_LAT(1), .CNTW(4)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .mem_read_e(mem_read_e), .branch_taken_e(branch_taken_e),
    .rd_m(rd_m), .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w),
    .forward_a_o(fa1), .forward_b_o(fb1), .stall_f_o(sf1), .stall_d_o(sd1),
    .flush_d_o(fd1), .flush_e_o(fe1), .stall_cycles_o(sc1));

  hazard_unit #(.LOAD_LAT(2), .CNTW(16)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .mem_read_e(mem_read_e), .branch_taken_e(branch_taken_e),
    .rd_m(rd_m), .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w),
    .forward_a_o(fa2), .forward_b_o(fb2), .stall_f_o(sf2), .stall_d_o(sd2),
    .flush_d_o(fd2), .flush_e_o(fe2), .stall_cycles_o(sc2));

  hazard_unit #(.LOAD_LAT(3), .CNTW(16)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .mem_read_e(mem_read_e), .branch_taken_e(branch_taken_e),
    .rd_m(rd_m), .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w),
    .forward_a_o(fa3), .forward_b_o(fb3), .stall_f_o(sf3), .stall_d_o(sd3),
    .flush_d_o(fd3), .flush_e_o(fe3), .stall_cycles_o(sc3));

  // Model: remaining stall cycles owed after the current one, plus a plain stall tally.
  int     lat[3]  = '{1, 2, 3};
  longint cmax[3] = '{15, 65535, 65535};
  int     left[3];
  longint cnt[3];

  function automatic logic m_hz();
    return mem_read_e && (rd_e != 0) &&
           ((use_rs1_d && rs1_d == rd_e) || (use_rs2_d && rs2_d == rd_e));
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'd1;
    if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic m_busy(input int i);
    return !rst && (left[i] > 0);
  endfunction

  function automatic logic m_stall(input int i);
    return m_busy(i) || (!branch_taken_e && m_hz());
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_inst(input int i, input logic [1:0] fa, input logic [1:0] fb,
                          input logic sf, input logic sd, input logic fd, input logic fe,
                          input logic [31:0] sc);
    chk($sformatf("lat%0d_fwd_a", lat[i]), 32'(fa), 32'(m_fwd(rs1_e)));
    chk($sformatf("lat%0d_fwd_b", lat[i]), 32'(fb), 32'(m_fwd(rs2_e)));
    chk($sformatf("lat%0d_stall_f", lat[i]), 32'(sf), 32'(m_stall(i)));
    chk($sformatf("lat%0d_stall_d", lat[i]), 32'(sd), 32'(m_stall(i)));
    chk($sformatf("lat%0d_flush_d", lat[i]), 32'(fd), 32'(branch_taken_e));
    chk($sformatf("lat%0d_flush_e", lat[i]), 32'(fe), 32'(m_busy(i) || branch_taken_e || m_hz()));
    chk($sformatf("lat%0d_stall_cycles", lat[i]), sc, 32'(cnt[i]));
  endtask

  always @(posedge clk) begin
    bit st;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        left[i] = 0;
        cnt[i]  = 0;
      end else begin
        st = m_stall(i);
        if (st && cnt[i] < cmax[i]) cnt[i] = cnt[i] + 1;
        if (left[i] > 0) left[i] = left[i] - 1;
        else if (!branch_taken_e && m_hz()) left[i] = lat[i] - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk_inst(0, fa1, fb1, sf1, sd1, fd1, fe1, 32'(sc1));
      chk_inst(1, fa2, fb2, sf2, sd2, fd2, fe2, 32'(sc2));
      chk_inst(2, fa3, fb3, sf3, sd3, fd3, fe3, 32'(sc3));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use(input logic on, input logic use2);
    mem_read_e = on; rd_e = 5'd3; rs2_d = 5'd3; use_rs2_d = use2;
    rs1_d = 5'd1; use_rs1_d = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    use_rs1_d = 0; use_rs2_d = 0; mem_read_e = 0; branch_taken_e = 0;
    reg_write_m = 0; reg_write_w = 0;
    cyc();
    checking = 1'b1;
    cyc();
    chk("rst_stall_cycles", 32'(sc2), 32'd0);
    chk("rst_stall_f", 32'(sf3), 32'd0);
    rst = 1'b0;

    // Forwarding vectors
    rs1_e = 5; rs2_e = 5; rd_m = 5; reg_write_m = 1; #1;
    chk("fwd_both_m_a", 32'(fa2), 32'd1);
    chk("fwd_both_m_b", 32'(fb2), 32'd1);
    cyc();
    rd_m = 7; rd_w = 7; reg_write_w = 1; rs1_e = 7; rs2_e = 3; #1;
    chk("fwd_m_priority", 32'(fa1), 32'd1);
    chk("fwd_no_match", 32'(fb1), 32'd0);
    cyc();
    rd_m = 0; rd_w = 0; rs1_e = 0; #1;
    chk("fwd_x0_none", 32'(fa3), 32'd0);
    cyc();
    rd_m = 4; rd_w = 9; rs1_e = 9; rs2_e = 4; #1;
    chk("fwd_w_a", 32'(fa2), 32'd2);
    chk("fwd_m_b", 32'(fb2), 32'd1);
    cyc();
    reg_write_m = 0; reg_write_w = 0;

    // Load-use hazard, one cycle of hz
    set_load_use(1'b1, 1'b1); #1;
    chk("hz_stall_first", 32'(sf2), 32'd1);
    cyc();
    set_load_use(1'b0, 1'b1); #1;
    chk("hz_lat2_second", 32'(sf2), 32'd1);
    chk("hz_lat1_done", 32'(sf1), 32'd0);
    cyc();
    chk("hz_lat2_done", 32'(sf2), 32'd0);
    chk("hz_lat3_third", 32'(sf3), 32'd1);
    cyc(); cyc();
    chk("hz_cnt_lat1", 32'(sc1), 32'd1);
    chk("hz_cnt_lat2", 32'(sc2), 32'd2);
    chk("hz_cnt_lat3", 32'(sc3), 32'd3);

    // Same registers, rs2 not used: no hazard
    set_load_use(1'b1, 1'b0); #1;
    chk("nouse_stall", 32'(sf2), 32'd0);
    chk("nouse_flush_e", 32'(fe2), 32'd0);
    cyc();
    set_load_use(1'b0, 1'b0);
    cyc();
    chk("nouse_cnt", 32'(sc2), 32'd2);

    // Branch and hz together: branch wins
    set_load_use(1'b1, 1'b1); branch_taken_e = 1; #1;
    chk("br_hz_flush_d", 32'(fd2), 32'd1);
    chk("br_hz_flush_e", 32'(fe2), 32'd1);
    chk("br_hz_stall", 32'(sf2), 32'd0);
    cyc();
    set_load_use(1'b0, 1'b1); branch_taken_e = 0; #1;
    chk("br_hz_idle", 32'(sf3), 32'd0);
    cyc();
    chk("br_hz_cnt", 32'(sc2), 32'd2);

    // Branch during WAIT
    set_load_use(1'b1, 1'b1);
    cyc();
    set_load_use(1'b0, 1'b1); branch_taken_e = 1; #1;
    chk("wait_br_flush_d", 32'(fd3), 32'd1);
    chk("wait_br_stall", 32'(sf3), 32'd1);
    cyc();
    branch_taken_e = 0;
    cyc(); cyc();

    // Reset in the second stall cycle of LOAD_LAT=3
    set_load_use(1'b1, 1'b1);
    cyc();
    set_load_use(1'b0, 1'b1); rst = 1; #1;
    chk("rst_mid_stall", 32'(sf3), 32'd0);
    cyc();
    rst = 0; #1;
    chk("rst_after_stall", 32'(sf3), 32'd0);
    chk("rst_after_cnt", 32'(sc3), 32'd0);
    cyc();

    // 20 back-to-back hazards
    set_load_use(1'b1, 1'b1);
    repeat (20) cyc();
    set_load_use(1'b0, 1'b1);
    cyc();
    chk("sat_cnt_lat1", 32'(sc1), 32'd15);
    chk("b2b_cnt_lat2", 32'(sc2), 32'd20);
    cyc(); cyc(); cyc();

    checking = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
